ame_det_pipe: RTL and testbench

AME_DET_PIPE -- requirements
Module: ame_det_pipe

---
 rtl/ame_det_pipe_if.sv | 42 ++++
 rtl/ame_det_pipe.sv | 147 ++++++++++++++
 tb/tb_ame_det_pipe.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ame_det_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface : ame_det_pipe_if
// Brief     : Input/output transaction bus for ame_det_pipe
// Revision  : 1.0 - initial release
// ============================================================================
interface ame_det_pipe_if #(
  parameter int DATA_BITS = 32,
  parameter int LANES     = 4,
  parameter int OUT_BITS  = 64
) ();

  localparam int c_sw = $clog2(2 * DATA_BITS + 1);

  // Input side: one transaction carries LANES x {M, D, L, C} plus mode fields
  logic                                  in_valid_i;
  logic                                  in_ready_o;
  logic [LANES-1:0][3:0][DATA_BITS-1:0]  in_data_i;
  logic                                  sign_i;
  logic                                  round_i;
  logic [c_sw-1:0]                       shift_i;

  // Output side: per-lane result and clamp flag
  logic                                  out_valid_o;
  logic                                  out_ready_i;
  logic [LANES-1:0][OUT_BITS-1:0]        out_data_o;
  logic [LANES-1:0]                      out_sat_o;

  // Block side
  modport slave (
    input  in_valid_i, in_data_i, sign_i, round_i, shift_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_sat_o
  );

  // Producer/consumer side
  modport master (
    output in_valid_i, in_data_i, sign_i, round_i, shift_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_sat_o
  );

endinterface
`default_nettype wire

// File: rtl/ame_det_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ame_det_pipe
// Brief    : Per-lane R = M*D - L*C at full precision, then optional
//            round-half-up, arithmetic right shift and saturation.
//            Three registered stages with a single global advance.
// Revision : 1.0 - initial release
// ============================================================================
module ame_det_pipe #(
  parameter int DATA_BITS = 32,
  parameter int LANES     = 4,
  parameter int OUT_BITS  = 64
) (
  input  wire            clk_i,
  input  wire            rst_i,
  ame_det_pipe_if.slave  bus,
  output logic           busy_o
);

  // Full-precision difference width and one guard bit for the rounding add
  localparam int c_fw = 2 * DATA_BITS + 1;
  localparam int c_xw = c_fw + 1;
  localparam int c_sw = $clog2(2 * DATA_BITS + 1);

  localparam logic [c_sw-1:0]        c_max_sh = c_sw'(2 * DATA_BITS);
  localparam logic [c_sw-1:0]        c_sh_one = c_sw'(1);
  localparam logic signed [c_xw-1:0] c_one    = c_xw'(1);
  localparam logic signed [c_xw-1:0] c_smax   = {{(c_xw-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [c_xw-1:0] c_smin   = {{(c_xw-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};
  localparam logic signed [c_xw-1:0] c_umax   = {{(c_xw-OUT_BITS){1'b0}}, {OUT_BITS{1'b1}}};

  // Operands are widened to the full result width so both signed and
  // unsigned products fit without wrap.
  function automatic logic signed [c_fw-1:0] ext_op(input logic [DATA_BITS-1:0] op,
                                                    input logic                 sgn);
    ext_op = {{(c_fw-DATA_BITS){sgn & op[DATA_BITS-1]}}, op};
  endfunction

  logic            w_adv;
  logic            r_s1_valid, r_s2_valid, r_s3_valid;
  logic            r_s1_sign,  r_s2_sign;
  logic            r_s1_round, r_s2_round;
  logic [c_sw-1:0] r_s1_shift, r_s2_shift;
  logic [c_sw-1:0] w_shift_clamped;

  // The whole pipeline moves together unless the output is held
  assign w_adv           = !r_s3_valid || bus.out_ready_i;
  assign bus.in_ready_o  = w_adv;
  assign bus.out_valid_o = r_s3_valid;
  assign busy_o          = r_s1_valid | r_s2_valid | r_s3_valid;

  assign w_shift_clamped = (bus.shift_i > c_max_sh) ? c_max_sh : bus.shift_i;

  // Stage valid bits shift on advance; reset empties every stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= bus.in_valid_i;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  // Mode fields travel alongside their data; stage 3 consumes stage-2 copies
  always_ff @(posedge clk_i) begin
    if (w_adv) begin
      r_s1_sign  <= bus.sign_i;
      r_s1_round <= bus.round_i;
      r_s1_shift <= w_shift_clamped;
      r_s2_sign  <= r_s1_sign;
      r_s2_round <= r_s1_round;
      r_s2_shift <= r_s1_shift;
    end
  end

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic signed [c_fw-1:0] w_m, w_d, w_l, w_c;
    logic signed [c_fw-1:0] r_md, r_lc, r_diff;
    logic signed [c_xw-1:0] w_rnd, w_sum, w_shr;
    logic [OUT_BITS-1:0]    w_res;
    logic                   w_sat;
    logic [OUT_BITS-1:0]    r_res;
    logic                   r_sat;

    assign w_m = ext_op(bus.in_data_i[n][3], bus.sign_i);
    assign w_d = ext_op(bus.in_data_i[n][2], bus.sign_i);
    assign w_l = ext_op(bus.in_data_i[n][1], bus.sign_i);
    assign w_c = ext_op(bus.in_data_i[n][0], bus.sign_i);

    // S1 captures the two products, S2 their difference
    always_ff @(posedge clk_i) begin
      if (w_adv) begin
        r_md   <= w_m * w_d;
        r_lc   <= w_l * w_c;
        r_diff <= r_md - r_lc;
      end
    end

    // Round-half-up, arithmetic shift, then clamp into the output range
    always_comb begin
      w_rnd = '0;
      if (r_s2_round && (r_s2_shift != '0)) begin
        w_rnd = c_one << (r_s2_shift - c_sh_one);
      end
      w_sum = {r_diff[c_fw-1], r_diff} + w_rnd;
      w_shr = w_sum >>> r_s2_shift;
      w_res = w_shr[OUT_BITS-1:0];
      w_sat = 1'b0;
      if (r_s2_sign) begin
        if (w_shr > c_smax) begin
          w_res = c_smax[OUT_BITS-1:0];
          w_sat = 1'b1;
        end else if (w_shr < c_smin) begin
          w_res = c_smin[OUT_BITS-1:0];
          w_sat = 1'b1;
        end
      end else begin
        if (w_shr[c_xw-1]) begin
          w_res = '0;
          w_sat = 1'b1;
        end else if (w_shr > c_umax) begin
          w_res = c_umax[OUT_BITS-1:0];
          w_sat = 1'b1;
        end
      end
    end

    // S3 output register; a bubble loads zeros so empty slots carry nothing
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_res <= '0;
        r_sat <= 1'b0;
      end else if (w_adv) begin
        r_res <= r_s2_valid ? w_res : '0;
        r_sat <= r_s2_valid & w_sat;
      end
    end

    assign bus.out_data_o[n] = r_res;
    assign bus.out_sat_o[n]  = r_sat;
  end

endmodule
`default_nettype wire

// File: tb/tb_ame_det_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ame_det_pipe
// Brief    : Directed self-checking bench; a 64-bit and a 16-bit output
//            instance run in lockstep on the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ame_det_pipe;

  logic clk = 1'b0;
  logic rst;
  logic busy_a, busy_b;
  int   checks   = 0;
  int   failures = 0;

  ame_det_pipe_if #(.DATA_BITS(32), .LANES(4), .OUT_BITS(64)) ifa ();
  ame_det_pipe_if #(.DATA_BITS(32), .LANES(4), .OUT_BITS(16)) ifb ();

  ame_det_pipe #(.DATA_BITS(32), .LANES(4), .OUT_BITS(64)) u_dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa),
    .busy_o(busy_a)
  );

  ame_det_pipe #(.DATA_BITS(32), .LANES(4), .OUT_BITS(16)) u_dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb),
    .busy_o(busy_b)
  );

  assign ifb.in_valid_i  = ifa.in_valid_i;
  assign ifb.in_data_i   = ifa.in_data_i;
  assign ifb.sign_i      = ifa.sign_i;
  assign ifb.round_i     = ifa.round_i;
  assign ifb.shift_i     = ifa.shift_i;
  assign ifb.out_ready_i = ifa.out_ready_i;

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int n, input logic [31:0] m, input logic [31:0] d,
                          input logic [31:0] l, input logic [31:0] c);
    ifa.in_data_i[n][3] = m;
    ifa.in_data_i[n][2] = d;
    ifa.in_data_i[n][1] = l;
    ifa.in_data_i[n][0] = c;
  endtask

  task automatic set_mode(input logic sgn, input logic rnd, input logic [6:0] sh);
    ifa.sign_i  = sgn;
    ifa.round_i = rnd;
    ifa.shift_i = sh;
  endtask

  // One transaction in; out_valid must appear after the third edge only
  task automatic launch(input string tag);
    ifa.in_valid_i = 1'b1;
    tick;
    ifa.in_valid_i = 1'b0;
    chk({tag, "_busy"}, busy_a, 1'b1);
    tick;
    chk({tag, "_lat2"}, ifa.out_valid_o, 1'b0);
    tick;
    chk({tag, "_valid"}, ifa.out_valid_o, 1'b1);
  endtask

  initial begin
    int sent;
    int recv;

    rst             = 1'b1;
    ifa.in_valid_i  = 1'b0;
    ifa.in_data_i   = '0;
    ifa.out_ready_i = 1'b1;
    set_mode(1'b0, 1'b0, 7'd0);
    tick;
    tick;
    chk("reset_out_valid", ifa.out_valid_o, 1'b0);
    chk("reset_busy",      busy_a, 1'b0);
    chk("reset_data",      ifa.out_data_o[0], 64'd0);
    chk("reset_sat",       ifa.out_sat_o, 4'd0);
    rst = 1'b0;
    chk("release_in_ready", ifa.in_ready_o, 1'b1);
    tick;

    // Signed basic: 3*5 - 2*4 = 7
    set_lane(0, 32'd3, 32'd5, 32'd2, 32'd4);
    set_mode(1'b1, 1'b0, 7'd0);
    launch("basic");
    chk("basic_l0",   ifa.out_data_o[0], 64'd7);
    chk("basic_sat",  ifa.out_sat_o[0], 1'b0);
    chk("basic_b_l0", ifb.out_data_o[0], 64'd7);
    tick;
    chk("basic_drain", ifa.out_valid_o, 1'b0);

    // R = -2*3 - 1*1 = -7; lane1 = 10000
    ifa.in_data_i = '0;
    set_lane(0, 32'hFFFF_FFFE, 32'd3, 32'd1, 32'd1);
    set_lane(1, 32'd100, 32'd100, 32'd0, 32'd0);
    set_mode(1'b1, 1'b1, 7'd1);
    launch("round");
    chk("round_l0",   ifa.out_data_o[0], 64'hFFFF_FFFF_FFFF_FFFD);
    chk("round_l1",   ifa.out_data_o[1], 64'd5000);
    chk("round_b_l0", ifb.out_data_o[0], 64'h0000_0000_0000_FFFD);
    tick;
    set_mode(1'b1, 1'b0, 7'd1);
    launch("trunc");
    chk("trunc_l0", ifa.out_data_o[0], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("trunc_l1", ifa.out_data_o[1], 64'd5000);
    tick;
    set_mode(1'b1, 1'b1, 7'd0);
    launch("sh0");
    chk("sh0_l0", ifa.out_data_o[0], 64'hFFFF_FFFF_FFFF_FFF9);
    tick;

    // Shift 127 clamps to 64: (R + 2^63) >> 64 = 0 for |R| small
    set_lane(1, 32'd3, 32'd5, 32'd2, 32'd4);
    set_mode(1'b1, 1'b1, 7'd127);
    launch("clamp");
    chk("clamp_l0",   ifa.out_data_o[0], 64'd0);
    chk("clamp_l1",   ifa.out_data_o[1], 64'd0);
    chk("clamp_sat",  ifa.out_sat_o, 4'd0);
    tick;

    // Unsigned: negative clamps to 0, max product fits 64 bits
    ifa.in_data_i = '0;
    set_lane(0, 32'd1, 32'd1, 32'd2, 32'd2);
    set_lane(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    set_mode(1'b0, 1'b0, 7'd0);
    launch("uns");
    chk("uns_l0",     ifa.out_data_o[0], 64'd0);
    chk("uns_l0_sat", ifa.out_sat_o[0], 1'b1);
    chk("uns_l1",     ifa.out_data_o[1], 64'hFFFF_FFFE_0000_0001);
    chk("uns_l1_sat", ifa.out_sat_o[1], 1'b0);
    chk("uns_b_l1",   ifb.out_data_o[1], 64'h0000_0000_0000_FFFF);
    chk("uns_b_sat",  ifb.out_sat_o, 4'b0011);
    tick;

    // 16-bit signed saturation in selected lanes only
    ifa.in_data_i = '0;
    set_lane(0, 32'd300, 32'd300, 32'd0, 32'd0);
    set_lane(1, 32'd3, 32'd5, 32'd2, 32'd4);
    set_lane(2, 32'hFFFF_FED4, 32'd300, 32'd0, 32'd0);
    set_mode(1'b1, 1'b0, 7'd0);
    launch("s16");
    chk("s16_b_l0",  ifb.out_data_o[0], 64'h7FFF);
    chk("s16_b_l1",  ifb.out_data_o[1], 64'd7);
    chk("s16_b_l2",  ifb.out_data_o[2], 64'h8000);
    chk("s16_b_l3",  ifb.out_data_o[3], 64'd0);
    chk("s16_b_sat", ifb.out_sat_o, 4'b0101);
    chk("s16_a_l0",  ifa.out_data_o[0], 64'd90000);
    chk("s16_a_l2",  ifa.out_data_o[2], 64'hFFFF_FFFF_FFFE_A070);
    chk("s16_a_sat", ifa.out_sat_o, 4'd0);
    tick;

    // Eight back-to-back inputs with out_ready pattern 1,0,0,1,...
    ifa.in_data_i = '0;
    set_mode(1'b1, 1'b0, 7'd0);
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      ifa.out_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if (sent < 8) begin
        ifa.in_valid_i = 1'b1;
        set_lane(0, 32'(sent + 1), 32'd10, 32'(sent), 32'd1);
      end else begin
        ifa.in_valid_i = 1'b0;
      end
      #2;
      chk("stream_in_ready", ifa.in_ready_o, !(ifa.out_valid_o && !ifa.out_ready_i));
      if (ifa.out_valid_o) begin
        chk("stream_data", ifa.out_data_o[0], 64'(9 * recv + 10));
      end
      if (ifa.in_valid_i && ifa.in_ready_o) sent++;
      if (ifa.out_valid_o && ifa.out_ready_i) recv++;
      tick;
    end
    chk("stream_sent", 64'(sent), 64'd8);
    chk("stream_recv", 64'(recv), 64'd8);
    ifa.in_valid_i  = 1'b0;
    ifa.out_ready_i = 1'b1;
    tick;

    // Reset with two transactions in flight
    ifa.in_data_i = '0;
    set_lane(0, 32'd100, 32'd100, 32'd0, 32'd0);
    ifa.in_valid_i = 1'b1;
    tick;
    tick;
    ifa.in_valid_i = 1'b0;
    chk("flight_busy", busy_a, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_busy",     busy_a, 1'b0);
    chk("mid_rst_valid",    ifa.out_valid_o, 1'b0);
    chk("mid_rst_data",     ifa.out_data_o[0], 64'd0);
    chk("mid_rst_in_ready", ifa.in_ready_o, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("mid_rst_no_ghost", ifa.out_valid_o, 1'b0);
    end
    set_lane(0, 32'd3, 32'd5, 32'd2, 32'd4);
    launch("post_rst");
    chk("post_rst_l0", ifa.out_data_o[0], 64'd7);
    tick;
    chk("post_rst_drain", ifa.out_valid_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
